id_exe_stage: RTL

ID_EXE_STAGE -- requirements
Module: id_exe_stage

---
 rtl/id_exe_stage_pkg.sv | 32 +++
 rtl/id_exe_refresh.sv | 31 +++
 rtl/id_exe_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/id_exe_stage_pkg.sv
// id_exe_stage_pkg
// Shared CPU constants used by the decoder, the hazard unit and the ID/EXE
// pipeline register: default datapath widths, the "no write" / "no access"
// bubble encodings and the bit layout of the packed execute-control bus.
package id_exe_stage_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 4;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_MEM_W  = 2;

  // Bubble encodings are all ones so that a cleared decoder field never
  // aliases a real register (r0 is a legal destination) or a real access.
  localparam logic [DEF_REG_W-1:0] NOP_REG_CODE = '1;
  localparam logic [DEF_MEM_W-1:0] NOP_MEM_CODE = '1;

  // Execute-control bus layout, LSB first.
  localparam int CTRL_ALUOP_LSB = 0;
  localparam int CTRL_ALUOP_W   = 4;
  localparam int CTRL_BR_LSB    = 4;
  localparam int CTRL_BR_W      = 2;
  localparam int CTRL_JUMP_BIT  = 6;
  localparam int CTRL_JBSEL_BIT = 7;

  typedef struct packed {
    logic       jb_sel;
    logic       jump;
    logic [1:0] br;
    logic [3:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/id_exe_refresh.sv
// id_exe_refresh
// Combinational operand select for one source operand of the ID/EXE stage.
// Replaces the operand with the late writeback value when that writeback
// targets the operand's source register.
// Ports:
//   fwd_en / fwd_reg / fwd_data : late writeback result of this cycle
//   src_reg                     : source register index being matched
//   base_data                   : operand value used when there is no hit
//   data                        : selected operand value
module id_exe_refresh
  import id_exe_stage_pkg::*;
#(
  parameter int                DATA_W  = DEF_DATA_W,
  parameter int                REG_W   = DEF_REG_W,
  parameter logic [REG_W-1:0]  NOP_REG = '1
) (
  input  logic              fwd_en,
  input  logic [REG_W-1:0]  fwd_reg,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic [REG_W-1:0]  src_reg,
  input  logic [DATA_W-1:0] base_data,
  output logic [DATA_W-1:0] data
);

  // A writeback to NOP_REG is not a real write and must never match,
  // even if an instruction happens to carry the NOP code as a source.
  logic hit;
  assign hit  = fwd_en && (fwd_reg != NOP_REG) && (fwd_reg == src_reg);
  assign data = hit ? fwd_data : base_data;

endmodule

// File: rtl/id_exe_stage.sv
// id_exe_stage
// ID/EXE pipeline register. Captures decoded operands and control on the
// falling clock edge, supports stall (hold), flush (bubble insertion) and
// refresh of held operands from a late writeback.
// Ports:
//   clk, rst (sync, active-low), stall, flush
//   *_in  : decoded instruction fields; *_out : registered copies
//   valid_in / valid_out : instruction is real
//   fwd_en / fwd_reg / fwd_data : late writeback result this cycle
//   hold_cnt : consecutive stall edges, saturating at 255
module id_exe_stage
  import id_exe_stage_pkg::*;
#(
  parameter int                DATA_W  = DEF_DATA_W,
  parameter int                REG_W   = DEF_REG_W,
  parameter int                CTRL_W  = DEF_CTRL_W,
  parameter int                MEM_W   = DEF_MEM_W,
  parameter logic [REG_W-1:0]  NOP_REG = '1,
  parameter logic [MEM_W-1:0]  NOP_MEM = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] rdata1_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [REG_W-1:0]  rreg1_in,
  input  logic [REG_W-1:0]  rreg2_in,
  input  logic [REG_W-1:0]  wreg_in,
  input  logic [DATA_W-1:0] imme_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [MEM_W-1:0]  mem_in,
  input  logic              wb_in,
  input  logic              fwd_en,
  input  logic [REG_W-1:0]  fwd_reg,
  input  logic [DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0] rdata1_out,
  output logic [DATA_W-1:0] rdata2_out,
  output logic [REG_W-1:0]  rreg1_out,
  output logic [REG_W-1:0]  rreg2_out,
  output logic [REG_W-1:0]  wreg_out,
  output logic [DATA_W-1:0] imme_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [MEM_W-1:0]  mem_out,
  output logic              wb_out,
  output logic              valid_out,
  output logic [7:0]        hold_cnt
);

  // While stalled the held operand is refreshed against the held source
  // index; otherwise the incoming operand is written through against the
  // incoming index. The same select block serves both cases.
  logic [REG_W-1:0]  src1, src2;
  logic [DATA_W-1:0] base1, base2, sel1, sel2;

  assign src1  = stall ? rreg1_out  : rreg1_in;
  assign src2  = stall ? rreg2_out  : rreg2_in;
  assign base1 = stall ? rdata1_out : rdata1_in;
  assign base2 = stall ? rdata2_out : rdata2_in;

  id_exe_refresh #(.DATA_W(DATA_W), .REG_W(REG_W), .NOP_REG(NOP_REG)) u_refresh1 (
    .fwd_en    (fwd_en),
    .fwd_reg   (fwd_reg),
    .fwd_data  (fwd_data),
    .src_reg   (src1),
    .base_data (base1),
    .data      (sel1)
  );

  id_exe_refresh #(.DATA_W(DATA_W), .REG_W(REG_W), .NOP_REG(NOP_REG)) u_refresh2 (
    .fwd_en    (fwd_en),
    .fwd_reg   (fwd_reg),
    .fwd_data  (fwd_data),
    .src_reg   (src2),
    .base_data (base2),
    .data      (sel2)
  );

  // The stage updates on the falling edge so EXE sees stable operands for
  // the whole high phase. Priority: reset, stall, flush, load.
  always_ff @(negedge clk) begin
    if (!rst) begin
      rdata1_out <= '0;
      rdata2_out <= '0;
      rreg1_out  <= '0;
      rreg2_out  <= '0;
      wreg_out   <= NOP_REG;
      imme_out   <= '0;
      pc_out     <= '0;
      ctrl_out   <= '0;
      mem_out    <= NOP_MEM;
      wb_out     <= 1'b0;
      valid_out  <= 1'b0;
      hold_cnt   <= 8'd0;
    end else if (stall) begin
      rdata1_out <= sel1;
      rdata2_out <= sel2;
      if (hold_cnt != 8'hFF) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end else begin
      rdata1_out <= sel1;
      rdata2_out <= sel2;
      rreg1_out  <= rreg1_in;
      rreg2_out  <= rreg2_in;
      imme_out   <= imme_in;
      pc_out     <= pc_in;
      ctrl_out   <= ctrl_in;
      hold_cnt   <= 8'd0;
      // A flushed instruction keeps its data fields for debug visibility
      // but loses every side effect.
      if (flush) begin
        wreg_out  <= NOP_REG;
        mem_out   <= NOP_MEM;
        wb_out    <= 1'b0;
        valid_out <= 1'b0;
      end else begin
        wreg_out  <= wreg_in;
        mem_out   <= mem_in;
        wb_out    <= wb_in;
        valid_out <= valid_in;
      end
    end
  end

endmodule
